// File: rtl/imem_arbiter.sv
// Single-port instruction memory controller: arbitrates fetch reads against loader writes,
// one access per cycle, with bounded fetch starvation and interrupt-area write protection.
module imem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int IVT_WORDS    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_gnt,
   output logic        fetch_rvalid,
   output logic [15:0] fetch_rdata,
   input  logic        flush,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [15:0] ld_wdata,
   output logic        ld_gnt,
   output logic        ld_err,
   input  logic        ivt_protect,
   output logic        mem_cs,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [19:0] IVT_LIM = 20'(IVT_WORDS);

   logic [3:0]  starve_cnt_reg, starve_cnt_next;
   logic        fetch_rvalid_reg;
   logic [15:0] fetch_rdata_reg;
   logic        ld_err_reg;
   logic        fetch_eff, fetch_win, ld_win, ld_prot;

   always_comb begin
      fetch_eff       = fetch_req & ~flush;
      ld_prot         = ivt_protect & (ld_addr[19:0] < IVT_LIM);
      fetch_win       = 1'b0;
      ld_win          = 1'b0;
      mem_cs          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_addr        = 32'd0;
      mem_wdata       = 16'd0;
      starve_cnt_next = starve_cnt_reg;

      // Nothing is granted while reset is held, so no write reaches the memory.
      if (rst_n) begin
         if (fetch_eff && (!ld_req || starve_cnt_reg >= LIMIT))
            fetch_win = 1'b1;
         else if (ld_req)
            ld_win = 1'b1;
      end

      if (fetch_win) begin
         mem_cs   = 1'b1;
         mem_read = 1'b1;
         mem_addr = fetch_addr;
      end else if (ld_win && !ld_prot) begin
         mem_cs    = 1'b1;
         mem_write = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end

      // A rejected write still counts as a loader grant that passed fetch over.
      if (!fetch_eff || fetch_win)
         starve_cnt_next = 4'd0;
      else if (ld_win && starve_cnt_reg != 4'd15)
         starve_cnt_next = starve_cnt_reg + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_reg   <= 4'd0;
         fetch_rvalid_reg <= 1'b0;
         fetch_rdata_reg  <= 16'd0;
         ld_err_reg       <= 1'b0;
      end else begin
         starve_cnt_reg   <= starve_cnt_next;
         fetch_rvalid_reg <= fetch_win;
         ld_err_reg       <= ld_win & ld_prot;
         if (fetch_win)
            fetch_rdata_reg <= mem_rdata;
      end
   end

   assign fetch_gnt    = fetch_win;
   assign ld_gnt       = ld_win;
   assign fetch_rvalid = fetch_rvalid_reg & ~flush;
   assign fetch_rdata  = fetch_rdata_reg;
   assign ld_err       = ld_err_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and randomized bench for imem_arbiter against a cycle-level reference model
// with its own shadow copy of the instruction memory.
module tb_imem_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int IVT_WORDS    = 32;

   logic        clk = 1'b0;
   logic        rst_n, fetch_req, flush, ld_req, ivt_protect;
   logic [31:0] fetch_addr, ld_addr;
   logic [15:0] ld_wdata;
   logic        fetch_gnt, fetch_rvalid, ld_gnt, ld_err;
   logic [15:0] fetch_rdata;
   logic        mem_cs, mem_read, mem_write;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   imem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .IVT_WORDS(IVT_WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .flush(flush),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .ld_err(ld_err), .ivt_protect(ivt_protect),
      .mem_cs(mem_cs), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural memory attached to the DUT (1K words aliased on addr[9:0]).
   logic [15:0] mem [0:1023];
   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk)
      if (mem_cs && mem_write) mem[mem_addr[9:0]] <= mem_wdata;

   // Reference model state.
   logic [15:0] ref_mem [0:1023];
   int          passed_over;
   bit          resp_due;
   logic [15:0] last_rdata;
   bit          err_due;

   int vectors = 0;
   int miscompares = 0;
   int fetch_grants = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      passed_over = 0;
      resp_due    = 0;
      last_rdata  = 16'd0;
      err_due     = 0;
   endtask

   // One clock cycle: inputs already applied after the falling edge.
   task automatic step();
      bit fe, e_fg, e_lg, e_prot, e_wr;
      #1;
      fe     = fetch_req && !flush;
      e_fg   = rst_n && fe && (!ld_req || passed_over >= STARVE_LIMIT);
      e_lg   = rst_n && ld_req && !e_fg;
      e_prot = ivt_protect && (ld_addr[19:0] < IVT_WORDS);
      e_wr   = e_lg && !e_prot;

      chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
      chk("ld_gnt", 32'(ld_gnt), 32'(e_lg));
      chk("mem_cs", 32'(mem_cs), 32'(e_fg || e_wr));
      chk("mem_read", 32'(mem_read), 32'(e_fg));
      chk("mem_write", 32'(mem_write), 32'(e_wr));
      chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (e_fg) chk("mem_addr_rd", mem_addr, fetch_addr);
      if (e_wr) begin
         chk("mem_addr_wr", mem_addr, ld_addr);
         chk("mem_wdata", 32'(mem_wdata), 32'(ld_wdata));
      end
      if (!e_fg && !e_lg) begin
         chk("mem_addr_idle", mem_addr, 32'd0);
         chk("mem_wdata_idle", 32'(mem_wdata), 32'd0);
      end
      chk("fetch_rvalid", 32'(fetch_rvalid), 32'(resp_due && !flush));
      chk("fetch_rdata", 32'(fetch_rdata), 32'(last_rdata));
      chk("ld_err", 32'(ld_err), 32'(err_due));
      if (e_fg) fetch_grants++;

      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         resp_due = e_fg;
         if (e_fg) last_rdata = ref_mem[fetch_addr[9:0]];
         err_due = e_lg && e_prot;
         if (e_wr) ref_mem[ld_addr[9:0]] = ld_wdata;
         if (e_fg || !fe) passed_over = 0;
         else if (e_lg) passed_over = (passed_over < 15) ? passed_over + 1 : 15;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      fetch_req = 0; flush = 0; ld_req = 0; ivt_protect = 0;
      fetch_addr = 0; ld_addr = 0; ld_wdata = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[32] = 16'h1940; ref_mem[32] = 16'h1940;
      mem[33] = 16'h2460; ref_mem[33] = 16'h2460;
      mem[34] = 16'h15A0; ref_mem[34] = 16'h15A0;
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      model_reset();

      // Reset held with both requesters active.
      fetch_req = 1; fetch_addr = 32'd40; ld_req = 1; ld_addr = 32'd200; ld_wdata = 16'h5555;
      repeat (3) step();
      rst_n = 1;
      step();
      chk("post_reset_first_ld", 32'(passed_over), 32'd1);
      idle_inputs();
      step();

      // Read stream.
      fetch_req = 1;
      for (int a = 32; a < 35; a++) begin
         fetch_addr = 32'(a);
         step();
      end
      fetch_req = 0;
      step();
      chk("stream_last_rdata", 32'(fetch_rdata), 32'h15A0);

      // Write then read.
      ld_req = 1; ld_addr = 32'd100; ld_wdata = 16'hBEEF;
      step();
      ld_req = 0; fetch_req = 1; fetch_addr = 32'd100;
      step();
      fetch_req = 0;
      step();
      chk("write_read_rdata", 32'(fetch_rdata), 32'hBEEF);

      // Starvation: L,L,L,L,F repeating.
      fetch_grants = 0;
      fetch_req = 1; fetch_addr = 32'd33; ld_req = 1;
      for (int i = 0; i < 10; i++) begin
         ld_addr = 32'(200 + i); ld_wdata = 16'($urandom);
         step();
      end
      chk("starve_fetch_grants", 32'(fetch_grants), 32'd2);
      idle_inputs();
      step();

      // Protected write rejected, then accepted when unprotected.
      ivt_protect = 1; ld_req = 1; ld_addr = 32'd5; ld_wdata = 16'hDEAD;
      step();
      idle_inputs();
      step();
      chk("protect_mem_unchanged", 32'(mem[5]), 32'(ref_mem[5]));
      ld_req = 1; ld_addr = 32'd5; ld_wdata = 16'hDEAD;
      step();
      idle_inputs();
      step();
      chk("unprotect_mem_written", 32'(mem[5]), 32'hDEAD);
      ivt_protect = 1; ld_req = 1; ld_addr = 32'h0010_0005; ld_wdata = 16'hCAFE;
      step();
      idle_inputs();
      step();

      // Flush masks the response of the preceding grant.
      fetch_req = 1; fetch_addr = 32'd40;
      step();
      flush = 1;
      step();
      flush = 0;
      step();
      idle_inputs();
      step();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         rst_n       = ($urandom_range(0, 49) != 0);
         fetch_req   = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 9) == 0);
         ld_req      = ($urandom_range(0, 1) == 1);
         ivt_protect = ($urandom_range(0, 1) == 1);
         fetch_addr  = {12'($urandom), 10'd0, 10'($urandom)};
         ld_addr     = {12'($urandom), 10'd0,
                        ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 40)) : 10'($urandom)};
         if ($urandom_range(0, 3) == 0) ld_addr[19:10] = 10'($urandom);
         ld_wdata    = 16'($urandom);
         step();
      end
      rst_n = 1;
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Single-port access controller for the 16-bit-word instruction memory: shares the memory between the fetch stage (reads) and the program loader (writes), one access per cycle. Drives the memory's chip-select, read, write, address and write-data pins, registers read data into a one-cycle response, and bounds fetch starvation. It also rejects loader writes into the interrupt area while protection is enabled. Sits between the fetch stage / loader and the instruction memory.

Parameters:
STARVE_LIMIT, 4, max consecutive loader grants while fetch waits before fetch is forced a grant (1..15)
IVT_WORDS, 32, size of protected interrupt area in words, starting at word 0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
fetch_req  in  1  fetch requests a read this cycle
fetch_addr  in  32  word address of read
fetch_gnt  out  1  read issued this cycle (combinational)
fetch_rvalid  out  1  registered; read data valid
fetch_rdata  out  16  registered read data
flush  in  1  cancel fetch this cycle and any response due next cycle
ld_req  in  1  loader requests a write
ld_addr  in  32  word address of write
ld_wdata  in  16  write data
ld_gnt  out  1  write accepted (combinational), including rejected writes
ld_err  out  1  registered; pulses 1 cycle after a rejected write
ivt_protect  in  1  1 = writes to addr[19:0] < IVT_WORDS rejected
mem_cs  out  1  memory chip select
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  32  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, combinational from mem_addr

Behaviour:
- Reset (rst_n=0 at clk edge): fetch_rvalid=0, fetch_rdata=0, ld_err=0, starve counter=0. While rst_n=0, all combinational outputs are forced 0: gnt, mem_cs, mem_read, mem_write, mem_addr, mem_wdata.
- Reset mid-operation: a read granted in the reset-assert cycle produces no response. No memory write occurs while rst_n=0.
- Arbitration, decided combinationally each cycle:
  - fetch_eff = fetch_req & ~flush.
  - Only ld_req: loader wins.
  - Only fetch_eff: fetch wins.
  - Both: fetch wins if starve_cnt >= STARVE_LIMIT, else loader wins.
  - Neither: mem_cs=mem_read=mem_write=0; mem_addr and mem_wdata = 0.
- Fetch grant: fetch_gnt=1, mem_cs=1, mem_read=1, mem_write=0, mem_addr=fetch_addr. On the clock edge, fetch_rdata<=mem_rdata and fetch_rvalid<=1. Latency is 1 cycle; back-to-back reads at full rate.
- Loader grant, legal write: ld_gnt=1, mem_cs=1, mem_write=1, mem_read=0, mem_addr=ld_addr, mem_wdata=ld_wdata. The memory commits the write at the edge.
- Loader grant, protected write (ivt_protect=1 and ld_addr[19:0] < IVT_WORDS):
  - ld_gnt=1, but mem_cs=mem_write=0.
  - ld_err<=1 next cycle.
  - The cycle is consumed: fetch is not granted.
- mem_read and mem_write are never both 1. Only addr[19:0] is decoded by the memory; upper bits are passed through unchanged.
- fetch_rvalid<=0 on any edge without a fetch grant. fetch_rdata holds its last value when rvalid=0.
- flush: blocks a fetch grant in the same cycle. If flush is high in the cycle after a grant, fetch_rvalid is forced 0 in that cycle (the output is masked). A new grant in the flush cycle is impossible, since fetch_eff=0.
- Starve counter (4-bit):
  - Increments on a loader grant while fetch_eff=1, saturating at 15.
  - Clears on a fetch grant, or when fetch_eff=0.
- ld_err<=0 on every edge without a rejected write.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with fetch_req=1 and ld_req=1 -> all outputs 0, no memory write. Release -> first grant goes to the loader, since starve_cnt=0.
- Read stream: fetch_req=1 at addrs 32,33,34, memory preloaded 0x1940,0x2460,0x15A0 -> fetch_gnt=1 each cycle, fetch_rvalid high from the next cycle, fetch_rdata=0x1940,0x2460,0x15A0 on consecutive cycles.
- Write then read: loader writes 0xBEEF to addr 100, then fetch reads 100 -> mem_write=1 for one cycle, fetch_rdata=0xBEEF one cycle after the read grant.
- Starvation: ld_req and fetch_req held high, STARVE_LIMIT=4 -> grant pattern L,L,L,L,F repeating. fetch_rvalid every 5th cycle.
- Protection: ivt_protect=1, ld_addr=5 -> ld_gnt=1, mem_write=0, ld_err=1 next cycle, mem[5] unchanged. Repeat with ivt_protect=0 -> write occurs, ld_err=0.
- Flush: grant fetch at addr 40, assert flush next cycle with fetch_req=1 -> fetch_rvalid=0 that cycle and fetch_gnt=0. Deassert flush -> normal grant resumes.
